// File: rtl/dlfloat16_square.sv
// DLFloat16 squarer: iterative 10-cycle shift-add multiply, two-step normalise/round, handshake out.
// Define DLF_SQ_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module dlfloat16_square (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dl_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dl_out,
    output logic [4:0]  exception_flags
);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_t;

    state_t      state_q, state_d;
    logic [15:0] op_q, op_d;
    logic [19:0] prod_q, prod_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [8:0]  e_q, e_d;
    logic [8:0]  frac_q, frac_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [15:0] dl_out_q, dl_out_d;
    logic [4:0]  flags_q, flags_d;

    logic [9:0]  sig;
    logic        is_nan, is_zero;
    logic        round_up, inexact, ovf, unf;
    logic [9:0]  frac_sum;
    logic [8:0]  e_r, frac_r;

    assign sig     = {op_q[14:9] != 6'd0, op_q[8:0]};
    assign is_nan  = (op_q[14:9] == 6'h3F) && (op_q[8:0] == 9'h1FF);
    assign is_zero = (op_q[14:9] == 6'd0);

`ifdef DLF_SQ_RNE_EN
    assign round_up = guard_q & (sticky_q | frac_q[0]);
`else
    assign round_up = 1'b0;
`endif

    assign inexact  = guard_q | sticky_q;
    assign frac_sum = {1'b0, frac_q} + {9'd0, round_up};
    // A rounding carry out of the fraction bumps the exponent and leaves a zero fraction.
    assign e_r      = frac_sum[9] ? e_q + 9'd1 : e_q;
    assign frac_r   = frac_sum[9] ? 9'd0 : frac_sum[8:0];
    assign ovf      = ($signed(e_r) > 9'sd63) || ((e_r == 9'd63) && (frac_r == 9'h1FF));
    assign unf      = ($signed(e_r) < 9'sd1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        e_d      = e_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        dl_out_d = dl_out_q;
        flags_d  = flags_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = dl_in;
                    prod_d  = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (sig[cnt_q]) prod_d = prod_q + ({10'd0, sig} << cnt_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    phase_d = 1'b0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (!phase_q) begin
                    phase_d  = 1'b1;
                    e_d      = {2'b00, op_q[14:9], 1'b0} - 9'd31 + {8'd0, prod_q[19]};
                    frac_d   = prod_q[19] ? prod_q[18:10] : prod_q[17:9];
                    guard_d  = prod_q[19] ? prod_q[9] : prod_q[8];
                    sticky_d = prod_q[19] ? |prod_q[8:0] : |prod_q[7:0];
                end else begin
                    phase_d = 1'b0;
                    state_d = StDone;
                    if (is_nan) begin
                        dl_out_d = 16'h7FFF;
                        flags_d  = 5'b10000;
                    end else if (is_zero) begin
                        dl_out_d = 16'h0000;
                        flags_d  = 5'b00000;
                    end else if (ovf) begin
                        dl_out_d = 16'h7FFE;
                        flags_d  = 5'b01010;
                    end else if (unf) begin
                        dl_out_d = 16'h0000;
                        flags_d  = 5'b01001;
                    end else begin
                        dl_out_d = {1'b0, e_r[5:0], frac_r};
                        flags_d  = {1'b0, inexact, 3'b000};
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 16'd0;
            prod_q   <= 20'd0;
            cnt_q    <= 4'd0;
            phase_q  <= 1'b0;
            e_q      <= 9'd0;
            frac_q   <= 9'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            dl_out_q <= 16'd0;
            flags_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            e_q      <= e_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            dl_out_q <= dl_out_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign out_valid       = (state_q == StDone);
    assign dl_out          = dl_out_q;
    assign exception_flags = flags_q;

endmodule

// File: tb/tb_dlfloat16_square.sv
// Scoreboard bench for dlfloat16_square: directed, random, stall, back-to-back and reset-abort cases.
module tb_dlfloat16_square;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dl_in = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] dl_out;
    logic [4:0]  exception_flags;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [20:0] exp_q[$];

    dlfloat16_square dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .dl_in          (dl_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dl_out         (dl_out),
        .exception_flags(exception_flags)
    );

    always #5 clk = ~clk;

    // Reference: {flags, result} computed from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [15:0] x);
        int unsigned ex, s, p, frac, g, st, rnd;
        int          e;
        ex = x[14:9];
        if (ex == 63 && x[8:0] == 9'h1FF) return {5'b10000, 16'h7FFF};
        if (ex == 0) return {5'b00000, 16'h0000};
        s = 512 + x[8:0];
        p = s * s;
        e = 2 * ex - 31;
        if (p >= (1 << 19)) begin
            e++;
            frac = (p >> 10) & 511;
            g    = (p >> 9) & 1;
            st   = ((p & 511) != 0) ? 1 : 0;
        end else begin
            frac = (p >> 9) & 511;
            g    = (p >> 8) & 1;
            st   = ((p & 255) != 0) ? 1 : 0;
        end
`ifdef DLF_SQ_RNE_EN
        rnd = g & (st | (frac & 1));
`else
        rnd = 0;
`endif
        frac = frac + rnd;
        if (frac == 512) begin
            frac = 0;
            e++;
        end
        if (e > 63 || (e == 63 && frac == 511)) return {5'b01010, 16'h7FFE};
        if (e < 1) return {5'b01001, 16'h0000};
        return {1'b0, (g | st) ? 1'b1 : 1'b0, 3'b000, 1'b0, 6'(e), 9'(frac)};
    endfunction

    // Entry and exit at posedge+#1. Stall >0 holds out_ready low that many cycles in DONE.
    task automatic apply(input logic [15:0] op, input bit hold_valid, input int stall);
        logic [20:0] exp;
        logic [15:0] held_out;
        logic [4:0]  held_flags;
        int          lat;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL ready_before_accept: got %b expected 1", in_ready);
        end
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        dl_in     = op;
        @(posedge clk);
        #1;
        exp_q.push_back(model(op));
        dl_in    = ~op;
        in_valid = hold_valid;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat != 12) begin
            n_miss++;
            $display("FAIL latency op=%h: got %0d expected 12", op, lat);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h0;
        n_vec++;
        if ({exception_flags, dl_out} !== exp) begin
            n_miss++;
            $display("FAIL result op=%h: got out=%h flags=%b expected out=%h flags=%b",
                     op, dl_out, exception_flags, exp[15:0], exp[20:16]);
        end
        held_out   = dl_out;
        held_flags = exception_flags;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dl_out !== held_out ||
                exception_flags !== held_flags) begin
                n_miss++;
                $display("FAIL done_hold cyc=%0d: got v=%b r=%b out=%h fl=%b expected v=1 r=0 out=%h fl=%b",
                         i, out_valid, in_ready, dl_out, exception_flags, held_out, held_flags);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dl_out !== held_out ||
            exception_flags !== held_flags) begin
            n_miss++;
            $display("FAIL release: got v=%b r=%b out=%h fl=%b expected v=0 r=1 out=%h fl=%b",
                     out_valid, in_ready, dl_out, exception_flags, held_out, held_flags);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dl_out !== 16'h0 || exception_flags !== 5'h0) begin
            n_miss++;
            $display("FAIL reset_state: got r=%b v=%b out=%h fl=%b expected r=1 v=0 out=0000 fl=00000",
                     in_ready, out_valid, dl_out, exception_flags);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ops[9];
        ops = '{16'h3E00, 16'hBF00, 16'h4000, 16'h3FFF, 16'h6400,
                16'h1400, 16'h7FFF, 16'h0000, 16'h7E00};
        // Check a couple of fixed expectations directly against the model.
        n_vec++;
        if (model(16'h3FFF) !== {5'b01000, 16'h41FE} || model(16'hBF00) !== {5'b0, 16'h4040}) begin
            n_miss++;
            $display("FAIL model_sanity: got %h %h expected 0841fe 004040",
                     model(16'h3FFF), model(16'hBF00));
        end
        foreach (ops[i]) apply(ops[i], 1'b0, 0);
    endtask

    task automatic test_done_hold();
        apply(16'h3FFF, 1'b0, 5);
    endtask

    task automatic test_random();
        logic [15:0] op;
        for (int i = 0; i < 16; i++) begin
            op = {1'($urandom), 6'($urandom_range(12, 50)), 9'($urandom)};
            apply(op, 1'b0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] op;
        for (int i = 0; i < 6; i++) begin
            op = {1'($urandom), 6'($urandom_range(20, 42)), 9'($urandom)};
            apply(op, 1'b1, 0);
        end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        in_valid = 1'b1;
        dl_in    = 16'h4123;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dl_out !== 16'h0 || exception_flags !== 5'h0) begin
            n_miss++;
            $display("FAIL reset_mid_mul: got r=%b v=%b out=%h fl=%b expected r=1 v=0 out=0000 fl=00000",
                     in_ready, out_valid, dl_out, exception_flags);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_miss++;
            $display("FAIL aborted_result: got out_valid=1 expected 0");
        end
        apply(16'hBF00, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_done_hold();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
